// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer for an 8x8 LED matrix.
//
// For each row 0..7 in turn, the sequencer fetches one byte from the frame-buffer
// read port using a req/ack handshake. It then blanks the panel for BLANK_TICKS
// cycles and drives the row for ROW_TICKS cycles. A blinking cursor is XORed
// into the column data. The blink half-period is BLINK_FRAMES full frames.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-low
//   en_i           scan enable; low parks the scan and darkens the panel
//   fb_rd_req_o    frame-buffer read request, held until acknowledged
//   fb_rd_row_o    row index being requested
//   fb_rd_ack_i    read accepted; fb_rd_data_i is valid in the same cycle
//   fb_rd_data_i   row pixels, bit n = column n
//   cur_x_i        cursor column
//   cur_y_i        cursor row
//   cur_en_i       cursor overlay enable
//   col_o          column drive, active-high
//   row_o          row select, active-low, one-cold while a row is shown
//   row_idx_o      current row index
//   frame_start_o  one-cycle pulse on entering the fetch of row 0
module matrix_scan_ctrl #(
    parameter int unsigned ROW_TICKS    = 8192,
    parameter int unsigned BLANK_TICKS  = 64,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic       fb_rd_req_o,
    output logic [2:0] fb_rd_row_o,
    input  logic       fb_rd_ack_i,
    input  logic [7:0] fb_rd_data_i,
    input  logic [2:0] cur_x_i,
    input  logic [2:0] cur_y_i,
    input  logic       cur_en_i,
    output logic [7:0] col_o,
    output logic [7:0] row_o,
    output logic [2:0] row_idx_o,
    output logic       frame_start_o
);

    localparam int unsigned MaxTicks = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
    localparam int unsigned FrameW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TickW-1:0]  RowLast   = TickW'(ROW_TICKS - 1);
    localparam logic [TickW-1:0]  BlankLast = TickW'(BLANK_TICKS - 1);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StBlank,
        StShow
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic              blink_q, blink_d;
    logic [7:0]        data_q, data_d;
    logic              req_q, req_d;
    logic [2:0]        row_idx_q, row_idx_d;
    logic              frame_start_q, frame_start_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;

    logic              cursor_hit;
    logic [7:0]        cursor_mask;

    // Cursor inputs only matter when they are sampled on the last blank cycle.
    // The column pattern is then frozen for the whole row.
    assign cursor_hit  = cur_en_i && blink_q && (cur_y_i == row_idx_q);
    assign cursor_mask = cursor_hit ? (8'd1 << cur_x_i) : 8'd0;

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        frame_d       = frame_q;
        blink_d       = blink_q;
        data_d        = data_q;
        req_d         = req_q;
        row_idx_d     = row_idx_q;
        frame_start_d = 1'b0;
        col_d         = col_q;
        row_d         = row_q;

        if (!en_i) begin
            // Park the scan. The blink state survives so the cursor cadence is not reset.
            state_d   = StIdle;
            req_d     = 1'b0;
            col_d     = 8'd0;
            row_d     = 8'hFF;
            row_idx_d = 3'd0;
            tick_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d       = StFetch;
                    req_d         = 1'b1;
                    row_idx_d     = 3'd0;
                    frame_start_d = 1'b1;
                    col_d         = 8'd0;
                    row_d         = 8'hFF;
                end
                StFetch: begin
                    if (req_q && fb_rd_ack_i) begin
                        data_d  = fb_rd_data_i;
                        req_d   = 1'b0;
                        tick_d  = '0;
                        state_d = StBlank;
                    end
                end
                StBlank: begin
                    if (tick_q == BlankLast) begin
                        tick_d  = '0;
                        state_d = StShow;
                        col_d   = data_q ^ cursor_mask;
                        row_d   = ~(8'd1 << row_idx_q);
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StShow: begin
                    if (tick_q == RowLast) begin
                        tick_d    = '0;
                        state_d   = StFetch;
                        req_d     = 1'b1;
                        col_d     = 8'd0;
                        row_d     = 8'hFF;
                        row_idx_d = row_idx_q + 3'd1;
                        if (row_idx_q == 3'd7) begin
                            frame_start_d = 1'b1;
                            if (frame_q == FrameLast) begin
                                frame_d = '0;
                                blink_d = ~blink_q;
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            tick_q        <= '0;
            frame_q       <= '0;
            blink_q       <= 1'b0;
            data_q        <= 8'd0;
            req_q         <= 1'b0;
            row_idx_q     <= 3'd0;
            frame_start_q <= 1'b0;
            col_q         <= 8'd0;
            row_q         <= 8'hFF;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            frame_q       <= frame_d;
            blink_q       <= blink_d;
            data_q        <= data_d;
            req_q         <= req_d;
            row_idx_q     <= row_idx_d;
            frame_start_q <= frame_start_d;
            col_q         <= col_d;
            row_q         <= row_d;
        end
    end

    // The requested row is the current row. It only advances while req is low.
    assign fb_rd_req_o   = req_q;
    assign fb_rd_row_o   = row_idx_q;
    assign row_idx_o     = row_idx_q;
    assign frame_start_o = frame_start_q;
    assign col_o         = col_q;
    assign row_o         = row_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl with short timing parameters.
// Rows are driven in lockstep, and every cycle's outputs are compared as one packed vector.
module tb_matrix_scan_ctrl;

    localparam int unsigned RowT   = 16;
    localparam int unsigned BlankT = 4;
    localparam int unsigned BlinkF = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic       ack   = 1'b0;
    logic [7:0] rdata = 8'd0;
    logic [2:0] cx    = 3'd0;
    logic [2:0] cy    = 3'd0;
    logic       cen   = 1'b0;

    logic       fb_rd_req;
    logic [2:0] fb_rd_row;
    logic [7:0] col;
    logic [7:0] row;
    logic [2:0] row_idx;
    logic       frame_start;

    int n_checks    = 0;
    int n_fail      = 0;
    int frames_done = 0;

    matrix_scan_ctrl #(
        .ROW_TICKS   (RowT),
        .BLANK_TICKS (BlankT),
        .BLINK_FRAMES(BlinkF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .fb_rd_req_o  (fb_rd_req),
        .fb_rd_row_o  (fb_rd_row),
        .fb_rd_ack_i  (ack),
        .fb_rd_data_i (rdata),
        .cur_x_i      (cx),
        .cur_y_i      (cy),
        .cur_en_i     (cen),
        .col_o        (col),
        .row_o        (row),
        .row_idx_o    (row_idx),
        .frame_start_o(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         delay;
        logic [7:0] data;
        logic       cen;
        logic [2:0] cx;
        logic [2:0] cy;
        logic [7:0] exp_col;
    } vec_t;

    vec_t tbl[32];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // fb_rd_row is only meaningful while a request is expected.
    task automatic check_out(input string name, input logic req, input int r, input logic fs,
                             input logic [7:0] rw, input logic [7:0] cl);
        logic [2:0]  rr;
        logic [23:0] e;
        logic [23:0] a;
        rr = r[2:0];
        e  = {req, req ? rr : 3'd0, rr, fs, rw, cl};
        a  = {fb_rd_req, req ? fb_rd_row : 3'd0, row_idx, frame_start, row, col};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s row %0d t=%0t: got {req,rd_row,idx,fs,row,col}=%h want %h",
                     name, r, $time, a, e);
        end
    endtask

    // Reference: blink phase flips every BlinkF completed frames since reset.
    function automatic logic [7:0] model_col(input logic [7:0] d, input int r, input int frames,
                                             input logic ce, input logic [2:0] x,
                                             input logic [2:0] y);
        logic [7:0] one;
        bit         phase;
        one   = 8'd1;
        phase = ((frames / BlinkF) % 2) == 1;
        if (ce && phase && int'(y) == r) return d ^ (one << x);
        return d;
    endfunction

    // Entered on the first fetch cycle of row r, and left on the first fetch cycle of the next row.
    // It acks after 'delay' extra cycles. mid_x >= 0 moves the cursor mid-row.
    // abort_at >= 0 pulls reset at that show cycle.
    task automatic do_row(input int r, input int delay, input logic [7:0] d,
                          input logic [7:0] exp_col, input int mid_x, input int abort_at);
        logic [7:0] one;
        logic [2:0] rr;
        one = 8'd1;
        rr  = r[2:0];
        for (int k = 0; k <= delay; k++) begin
            check_out("fetch", 1'b1, r, (k == 0 && r == 0), 8'hFF, 8'h00);
            if (k == delay) begin
                ack   = 1'b1;
                rdata = d;
            end else begin
                ack   = 1'b0;
                rdata = 8'($urandom);
            end
            step();
        end
        for (int b = 0; b < int'(BlankT); b++) begin
            check_out("blank", 1'b0, r, 1'b0, 8'hFF, 8'h00);
            ack   = 1'($urandom);
            rdata = 8'($urandom);
            step();
        end
        for (int s = 0; s < int'(RowT); s++) begin
            check_out("show", 1'b0, r, 1'b0, ~(one << rr), exp_col);
            if (s == abort_at) begin
                #2 rst = 1'b0;
                #1 check_out("async_rst", 1'b0, 0, 1'b0, 8'hFF, 8'h00);
                ack = 1'b0;
                return;
            end
            if (s == 4 && mid_x >= 0) cx = 3'(mid_x);
            ack   = 1'($urandom);
            rdata = 8'($urandom);
            step();
        end
    endtask

    task automatic rand_row(input int r);
        int         dly;
        logic [7:0] d;
        dly = $urandom_range(0, 3);
        d   = 8'($urandom);
        cen = 1'($urandom);
        cx  = 3'($urandom);
        cy  = ($urandom % 2 == 0) ? 3'(r) : 3'($urandom);
        do_row(r, dly, d, model_col(d, r, frames_done, cen, cx, cy), -1, -1);
        if (r == 7) frames_done++;
    endtask

    task automatic rand_frame();
        for (int r = 0; r < 8; r++) rand_row(r);
    endtask

    initial begin
        // Frame 0: plain 0x81 rows with a long ack on row 3.
        // Frames 1..3 show a blinking cursor at (5,2).
        for (int i = 0; i < 32; i++) begin
            int f;
            int r;
            f = i / 8;
            r = i % 8;
            if (f == 0) begin
                tbl[i] = '{delay: (r == 3) ? 10 : 1, data: 8'h81, cen: 1'b0, cx: 3'd0,
                           cy: 3'd0, exp_col: 8'h81};
            end else begin
                tbl[i] = '{delay: 1, data: 8'h00, cen: 1'b1, cx: 3'd5, cy: 3'd2,
                           exp_col: (f >= 2 && r == 2) ? 8'h20 : 8'h00};
            end
        end

        #2 rst = 1'b0;
        #2 check_out("reset_async", 1'b0, 0, 1'b0, 8'hFF, 8'h00);
        step();
        step();
        check_out("reset_hold", 1'b0, 0, 1'b0, 8'hFF, 8'h00);
        rst = 1'b1;
        step();
        check_out("idle_en_low", 1'b0, 0, 1'b0, 8'hFF, 8'h00);
        en = 1'b1;
        step();

        for (int i = 0; i < 32; i++) begin
            cen = tbl[i].cen;
            cx  = tbl[i].cx;
            cy  = tbl[i].cy;
            do_row(i % 8, tbl[i].delay, tbl[i].data, tbl[i].exp_col, -1, -1);
            if (i % 8 == 7) frames_done++;
        end

        rand_frame();
        rand_frame();

        // Moving the cursor mid-row takes effect only in the next frame (frames 6,7: phase 1).
        cen = 1'b1;
        cx  = 3'd2;
        cy  = 3'd3;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 8; r++) begin
                do_row(r, 1, 8'h00, (r == 3) ? ((f == 0) ? 8'h04 : 8'h40) : 8'h00,
                       (f == 0 && r == 3) ? 6 : -1, -1);
            end
            frames_done++;
        end

        rand_frame();

        // Drop en while row 3 waits for ack. The frame counter must survive the drop.
        for (int r = 0; r < 3; r++) rand_row(r);
        ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_out("fetch_noack", 1'b1, 3, 1'b0, 8'hFF, 8'h00);
            step();
        end
        en = 1'b0;
        step();
        check_out("en_drop", 1'b0, 0, 1'b0, 8'hFF, 8'h00);
        for (int k = 0; k < 3; k++) begin
            ack = 1'($urandom);
            step();
            check_out("idle_parked", 1'b0, 0, 1'b0, 8'hFF, 8'h00);
        end
        ack = 1'b0;
        en  = 1'b1;
        step();
        rand_frame();
        rand_frame();

        // Asynchronous reset in the middle of row 5's show period.
        for (int r = 0; r < 5; r++) rand_row(r);
        do_row(5, 0, 8'hA5, 8'hA5, -1, 7);
        frames_done = 0;
        step();
        check_out("reset_mid_row", 1'b0, 0, 1'b0, 8'hFF, 8'h00);
        rst = 1'b1;
        step();
        for (int f = 0; f < 3; f++) rand_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
